// File: rtl/bias_seq_pkg.sv
// bias_seq_pkg: shared FSM state type, skid sizing and address-width helper for the bias sequencer.
package bias_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bias_seq_if.sv
// bias_seq_if: control, ROM and output-stream signals of the bias sequencer.
interface bias_seq_if #(
   parameter int MEM_SIZE   = 8,
   parameter int DATA_WIDTH = 16,
   parameter int PASS_W     = 16
);
   localparam int AW = bias_seq_pkg::addr_w(MEM_SIZE);
   logic                  ap_start;
   logic [PASS_W-1:0]     cfg_passes;
   logic                  ap_idle;
   logic                  ap_done;
   logic [AW-1:0]         rom_addr;
   logic                  rom_ce;
   logic [DATA_WIDTH-1:0] rom_q;
   logic [DATA_WIDTH-1:0] output_V_din;
   logic                  output_V_full_n;
   logic                  output_V_write;
   modport master (
      input  ap_start, cfg_passes, rom_q, output_V_full_n,
      output ap_idle, ap_done, rom_addr, rom_ce, output_V_din, output_V_write
   );
   modport slave (
      output ap_start, cfg_passes, rom_q, output_V_full_n,
      input  ap_idle, ap_done, rom_addr, rom_ce, output_V_din, output_V_write
   );
endinterface

// File: rtl/bias_skid_fifo.sv
// bias_skid_fifo: 2-entry registered FIFO absorbing the ROM read latency under backpressure.
module bias_skid_fifo
   import bias_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [DATA_WIDTH-1:0] i_din,
   output logic [DATA_WIDTH-1:0] o_dout,
   output logic [OCC_W-1:0]      o_occ
);
   logic [DATA_WIDTH-1:0] r_d0, r_d1;
   logic [OCC_W-1:0]      r_occ;
   logic [OCC_W-1:0]      w_wpos;
   // slot the new word lands in once this cycle's pop has shifted the head out
   assign w_wpos = r_occ - OCC_W'(i_pop);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_occ <= '0;
      end else begin
         r_d0  <= (i_push && w_wpos == '0) ? i_din : i_pop ? r_d1 : r_d0;
         r_d1  <= (i_push && w_wpos == OCC_W'(1)) ? i_din : r_d1;
         r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
      end
   assign o_dout = r_d0;
   assign o_occ  = r_occ;
endmodule

// File: rtl/bias_seq.sv
// bias_seq: streams the bias ROM vector cfg_passes times into an ap_fifo, honouring full_n.
module bias_seq
   import bias_seq_pkg::*;
#(
   parameter int MEM_SIZE   = 8,
   parameter int DATA_WIDTH = 16,
   parameter int PASS_W     = 16
) (
   input logic       ap_clk,
   input logic       ap_rst,
   bias_seq_if.master bus
);
   localparam int AW = addr_w(MEM_SIZE);
   state_t                r_state;
   logic [AW-1:0]         r_addr;
   logic [PASS_W-1:0]     r_pass, r_passes;
   logic                  r_inflight, r_idle, r_done;
   logic [OCC_W-1:0]      w_occ;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_pop, w_issue, w_wrap, w_last, w_empty_nxt;
   assign w_pop = (w_occ != '0) && bus.output_V_full_n;
   // credit: words held plus in flight after this cycle's pop must leave room for one more
   assign w_issue = (r_state == RUN) && (3'(w_occ) + 3'(r_inflight) <= 3'(w_pop) + 3'd1);
   assign w_wrap = r_addr == AW'(MEM_SIZE - 1);
   assign w_last = w_wrap && (r_pass == r_passes - 1'b1);
   assign w_empty_nxt = 3'(w_occ) + 3'(r_inflight) == 3'(w_pop);
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_pass     <= '0;
         r_passes   <= '0;
         r_inflight <= 1'b0;
         r_idle     <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         case (r_state)
            IDLE: if (bus.ap_start) begin
               r_idle <= 1'b0;
               if (bus.cfg_passes != '0) begin
                  r_passes <= bus.cfg_passes;
                  r_addr   <= '0;
                  r_pass   <= '0;
                  r_state  <= RUN;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            RUN: if (w_issue) begin
               r_addr <= w_wrap ? '0 : r_addr + 1'b1;
               if (w_wrap) r_pass <= r_pass + 1'b1;
               if (w_last) r_state <= DRAIN;
            end
            DRAIN: if (w_empty_nxt) begin
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_idle  <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   bias_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk    (ap_clk),
      .rst    (ap_rst),
      .i_push (r_inflight),
      .i_pop  (w_pop),
      .i_din  (bus.rom_q),
      .o_dout (w_head),
      .o_occ  (w_occ)
   );
   assign bus.ap_idle        = r_idle;
   assign bus.ap_done        = r_done;
   assign bus.rom_addr       = r_addr;
   assign bus.rom_ce         = w_issue;
   assign bus.output_V_din   = w_head;
   assign bus.output_V_write = w_pop;
endmodule
